dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store path and a DMA/debug requester.
- Grants at most one access per cycle and drives the dmem command bus.
- Returns read data one cycle after grant, registered per requester.
- A bounded-burst round-robin policy prevents either side from starving the other.
- Sits between the CPU datapath/control and dmem; cpu_stall feeds the PC-write enable path.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_BURST, 4, max consecutive grants to one owner while the other requester is waiting (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  DATA_W  CPU load data
- dma_req  in  1  DMA access request
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- mem_read  out  1  dmem read enable
- mem_write  out  1  dmem write enable
- mem_addr  out  ADDR_W  dmem address
- mem_wdata  out  DATA_W  dmem write data
- mem_rdata  in  DATA_W  dmem read data, combinational, same cycle as mem_read

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values:
  - owner = NONE, burst_cnt = 0.
  - cpu_rvalid = dma_rvalid = 0; cpu_rdata = dma_rdata = 0.
  - Grants and mem_* outputs are combinational and are all 0 while rst is high.
- FSM: owner ∈ {NONE, CPU, DMA}; it records the last granted requester.
- Grant decision (combinational, from req and owner/burst_cnt):
  - Only one requester active: grant it.
  - Both active, owner = NONE: grant CPU.
  - Both active, owner = X, burst_cnt < MAX_BURST: grant X.
  - Both active, burst_cnt ≥ MAX_BURST: grant the other requester.
  - Neither active: no grant.
  - cpu_gnt and dma_gnt are never both 1.
- Command mux:
  - Granted requester's addr and wdata drive mem_addr and mem_wdata.
  - mem_write = gnt & we; mem_read = gnt & ~we.
  - No grant: mem_read = mem_write = 0; mem_addr and mem_wdata = 0.
- State update at posedge:
  - Grant to the same owner: burst_cnt = min(burst_cnt + 1, MAX_BURST).
  - Grant to a different owner: owner = new, burst_cnt = 1.
  - No grant: owner held, burst_cnt = 0.
- Read return:
  - A read granted in cycle N captures mem_rdata into that requester's rdata register.
  - The matching rvalid is high in cycle N+1 only (single-cycle pulse).
  - rdata holds its value until the next read for that requester.
  - Writes never assert rvalid.
- Back-to-back reads: rvalid stays high on consecutive cycles with new data each cycle.
- Requesters must hold req/we/addr/wdata stable until gnt. Dropping req before gnt is legal; the request is simply abandoned.
- Reset mid-operation: a pending rvalid is cleared immediately and the read is lost. owner returns to NONE.
- Throughput: one access per cycle, zero-bubble on owner switch.
- Worst-case wait for a continuously requesting side: MAX_BURST cycles.

Decomposition:
- Shared package/def file:
  - owner encoding constants: OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2.
  - ADDR_W/DATA_W defaults alongside the existing opcode definitions.
- One natural sub-module: rr_grant. It holds the owner/burst_cnt state and emits the two grants.
- Command mux and read-return registers stay in dmem_arbiter.

Test Plan:
- Reset then CPU-only traffic: cpu_req = 1, we = 0, addr = 0x0010, mem_rdata = 0xBEEF. Required: cpu_gnt = 1 and cpu_stall = 0 the same cycle; mem_read = 1, mem_addr = 0x0010; next cycle cpu_rvalid = 1, cpu_rdata = 0xBEEF; dma_rvalid stays 0.
- Simultaneous first request after reset: both req, CPU write of 0x1234 to 0x0020, DMA read of 0x0030. Required: CPU is granted first with mem_write = 1, mem_wdata = 0x1234; DMA is granted the next cycle (CPU drops req).
- Starvation bound: CPU and DMA both request continuously with MAX_BURST = 4. Required grant sequence: CPU ×4, DMA ×4, CPU ×4. cpu_stall = 1 exactly during the DMA cycles.
- Idle resets burst: CPU granted 3 cycles, then 1 idle cycle, then both request. Required: CPU is granted 4 more consecutive cycles before DMA.
- Back-to-back DMA reads at 0x0040 and 0x0041 returning 0xAAAA and 0x5555. Required: dma_rvalid high for two consecutive cycles carrying those values in order.
- Async reset in the cycle after a granted read: assert rst mid-cycle. Required: dma_rvalid drops immediately without a clock edge; after release owner = NONE and the first contended grant goes to CPU.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, default
// bus widths and the dmem command opcode.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  typedef enum logic [1:0] {
    OWNER_NONE = OWN_NONE,
    OWNER_CPU  = OWN_CPU,
    OWNER_DMA  = OWN_DMA
  } owner_e;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_e;

  function automatic mem_op_e mem_op(input logic gnt, input logic we);
    if (!gnt)    return MEM_IDLE;
    else if (we) return MEM_WRITE;
    else         return MEM_READ;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response/command bus around the dmem arbiter. The slave modport
// is the arbiter's view; master is the surrounding CPU/DMA/dmem side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_grant.sv
// Bounded-burst round-robin grant between CPU and DMA. Tracks the last owner
// and how many consecutive grants it has taken.
module rr_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  output logic cpu_gnt,
  output logic dma_gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  owner_e           owner_q, owner_d, gnt_own;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWNER_NONE;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    owner_d = owner_q;
    cnt_d   = '0;
    gnt_own = OWNER_NONE;
    if (!rst) begin
      if (cpu_req && dma_req) begin
        if (owner_q == OWNER_NONE) begin
          cpu_gnt = 1'b1;
        end else if (cnt_q < CNT_MAX) begin
          cpu_gnt = (owner_q == OWNER_CPU);
          dma_gnt = (owner_q == OWNER_DMA);
        end else begin
          // burst budget spent while the other side waits: hand over
          cpu_gnt = (owner_q == OWNER_DMA);
          dma_gnt = (owner_q == OWNER_CPU);
        end
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
    if (cpu_gnt || dma_gnt) begin
      gnt_own = cpu_gnt ? OWNER_CPU : OWNER_DMA;
      if (gnt_own == owner_q) begin
        cnt_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : CNT_MAX;
      end else begin
        owner_d = gnt_own;
        cnt_d   = CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between CPU load/store and a DMA/debug port:
// one access per cycle, read data registered per requester one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst,
  dmem_arbiter_if.slave bus
);

  logic              cpu_gnt, dma_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  mem_op_e           op;
  logic              cpu_rd, dma_rd;

  rr_grant #(.MAX_BURST(MAX_BURST)) u_rr_grant (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .cpu_gnt (cpu_gnt),
    .dma_gnt (dma_gnt)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (cpu_gnt) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  assign op            = mem_op(cpu_gnt | dma_gnt, sel_we);
  assign bus.mem_read  = (op == MEM_READ);
  assign bus.mem_write = (op == MEM_WRITE);
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

  assign cpu_rd = cpu_gnt & ~bus.cpu_we;
  assign dma_rd = dma_gnt & ~bus.dma_we;

  // rdata registers only load on a read so they hold between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.dma_rdata  <= '0;
    end else begin
      bus.cpu_rvalid <= cpu_rd;
      bus.dma_rvalid <= dma_rd;
      if (cpu_rd) bus.cpu_rdata <= bus.mem_rdata;
      if (dma_rd) bus.dma_rdata <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and read
// returns, a negedge monitor pops and compares whatever the DUT presents.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        cpu;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        stall;
  } gexp_t;

  typedef struct {
    logic        cpu;
    logic [15:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                       input logic [15:0] rd);
    bus.cpu_req   = cr;  bus.cpu_we = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;
    bus.dma_req   = dr;  bus.dma_we = dw;  bus.dma_addr = da;  bus.dma_wdata = dd;
    bus.mem_rdata = rd;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic exp_g(input logic cpu, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic stall);
    gexp_t g;
    g.cpu = cpu; g.rd = ~we; g.wr = we; g.addr = addr; g.wdata = wdata; g.stall = stall;
    gq.push_back(g);
  endtask

  task automatic exp_r(input logic cpu, input logic [15:0] data);
    rexp_t r;
    r.cpu = cpu; r.data = data;
    rq.push_back(r);
  endtask

  // monitor
  initial begin : mon
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (bus.cpu_gnt || bus.dma_gnt) begin
        chk("gnt_onehot", {31'b0, bus.cpu_gnt & bus.dma_gnt}, 0);
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 1, 0);
        end else begin
          g = gq.pop_front();
          chk("cpu_gnt",   {31'b0, bus.cpu_gnt},   {31'b0, g.cpu});
          chk("dma_gnt",   {31'b0, bus.dma_gnt},   {31'b0, ~g.cpu});
          chk("mem_read",  {31'b0, bus.mem_read},  {31'b0, g.rd});
          chk("mem_write", {31'b0, bus.mem_write}, {31'b0, g.wr});
          chk("mem_addr",  {16'b0, bus.mem_addr},  {16'b0, g.addr});
          chk("mem_wdata", {16'b0, bus.mem_wdata}, {16'b0, g.wdata});
          chk("cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, g.stall});
        end
      end
      if (bus.cpu_rvalid || bus.dma_rvalid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("cpu_rvalid", {31'b0, bus.cpu_rvalid}, {31'b0, r.cpu});
          chk("dma_rvalid", {31'b0, bus.dma_rvalid}, {31'b0, ~r.cpu});
          chk("rdata", {16'b0, (r.cpu ? bus.cpu_rdata : bus.dma_rdata)}, {16'b0, r.data});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    // reset state, with both requests asserted to show the gating
    idle();
    #2;
    drive(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0030, 16'h0, 16'h1111);
    #1;
    chk("rst_cpu_gnt",    {31'b0, bus.cpu_gnt},    0);
    chk("rst_dma_gnt",    {31'b0, bus.dma_gnt},    0);
    chk("rst_mem_read",   {31'b0, bus.mem_read},   0);
    chk("rst_mem_write",  {31'b0, bus.mem_write},  0);
    chk("rst_mem_addr",   {16'b0, bus.mem_addr},   0);
    chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 0);
    chk("rst_dma_rvalid", {31'b0, bus.dma_rvalid}, 0);
    chk("rst_cpu_rdata",  {16'b0, bus.cpu_rdata},  0);
    chk("rst_dma_rdata",  {16'b0, bus.dma_rdata},  0);
    do_reset();

    // T1: CPU-only load
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 16'hBEEF);
    exp_g(1, 0, 16'h0010, 16'h0, 0);
    exp_r(1, 16'hBEEF);
    step();
    idle();
    step();
    chk("t1_rvalid_pulse", {31'b0, bus.cpu_rvalid}, 0);
    chk("t1_rdata_hold",   {16'b0, bus.cpu_rdata},  32'hBEEF);

    // T2: simultaneous first request after reset
    do_reset();
    drive(1, 1, 16'h0020, 16'h1234, 1, 0, 16'h0030, 16'h0, 16'h0);
    exp_g(1, 1, 16'h0020, 16'h1234, 0);
    step();
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0030, 16'h0, 16'h7777);
    exp_g(0, 0, 16'h0030, 16'h0, 0);
    exp_r(0, 16'h7777);
    step();
    idle();
    step();

    // T3: starvation bound, CPU x4 / DMA x4 / CPU x4
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 16'h0100 + 16'(i), 16'h0, 1, 1, 16'h0200 + 16'(i), 16'hD000 + 16'(i),
            16'hC000 + 16'(i));
      if (i >= 4 && i < 8) begin
        exp_g(0, 1, 16'h0200 + 16'(i), 16'hD000 + 16'(i), 1);
      end else begin
        exp_g(1, 0, 16'h0100 + 16'(i), 16'h0, 0);
        exp_r(1, 16'hC000 + 16'(i));
      end
      step();
    end
    idle();
    step();

    // T4: idle cycle clears the burst count
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'h0300 + 16'(i), 16'h00A0 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0);
      exp_g(1, 1, 16'h0300 + 16'(i), 16'h00A0 + 16'(i), 0);
      step();
    end
    idle();
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 16'h0310 + 16'(i), 16'h00B0 + 16'(i), 1, 0, 16'h0400, 16'h0, 16'h4440 + 16'(i));
      if (i < 4) begin
        exp_g(1, 1, 16'h0310 + 16'(i), 16'h00B0 + 16'(i), 0);
      end else begin
        exp_g(0, 0, 16'h0400, 16'h0, 1);
        exp_r(0, 16'h4444);
      end
      step();
    end
    idle();
    step();

    // T5: back-to-back DMA reads
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0, 16'hAAAA);
    exp_g(0, 0, 16'h0040, 16'h0, 0);
    exp_r(0, 16'hAAAA);
    step();
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0041, 16'h0, 16'h5555);
    exp_g(0, 0, 16'h0041, 16'h0, 0);
    exp_r(0, 16'h5555);
    step();
    idle();
    step();
    chk("t5_rvalid_off", {31'b0, bus.dma_rvalid}, 0);
    chk("t5_rdata_hold", {16'b0, bus.dma_rdata},  32'h5555);

    // T6: async reset while a DMA read return is pending
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0050, 16'h0, 16'h1357);
    exp_g(0, 0, 16'h0050, 16'h0, 0);
    step();
    idle();
    chk("t6_rvalid_before", {31'b0, bus.dma_rvalid}, 1);
    chk("t6_rdata_before",  {16'b0, bus.dma_rdata},  32'h1357);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rvalid_async", {31'b0, bus.dma_rvalid}, 0);
    chk("t6_rdata_async",  {16'b0, bus.dma_rdata},  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 1, 16'h0060, 16'h0CAF, 1, 1, 16'h0070, 16'h0D0D, 16'h0);
    exp_g(1, 1, 16'h0060, 16'h0CAF, 0);
    step();
    idle();
    step();
    step();

    chk("gnt_queue_drained",    gq.size(), 0);
    chk("rvalid_queue_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
